usb_audio_i2s_tx: RTL and testbench

//  Serialises the 48 kHz 16-bit stereo PCM words that the USB audio core presents on audio_lch/audio_rch into an I2S stream for an external DAC.
//  It sits directly downstream of usb_audio_top in the 60 MHz clk domain.
//  It generates BCLK (64 fs) and LRCK (fs) from clk with a fractional phase accumulator, because 60 MHz is not an integer multiple of 3.072 MHz.

---
 rtl/usb_audio_pkg.sv | 10 +
 rtl/usb_audio_nco.sv | 28 ++
 rtl/usb_audio_i2s_tx.sv | 136 +++++++++++++
 tb/tb_usb_audio_i2s_tx.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/usb_audio_pkg.sv
// Shared types and frame geometry for the USB audio I2S transmitter.
package usb_audio_pkg;

   typedef enum logic [1:0] {IDLE, RUN, DRAIN} i2s_state_t;

   localparam int I2S_SLOT_BITS  = 32;
   localparam int I2S_FRAME_BITS = 64;
   localparam int PCM_W          = 16;

endpackage

// File: rtl/usb_audio_nco.sv
// Fractional phase accumulator; tick is the carry out of acc + INC.
module usb_audio_nco #(
   parameter int               ACC_W = 24,
   parameter logic [ACC_W-1:0] INC   = 24'd1717987
) (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   output logic tick
);

   logic [ACC_W-1:0] acc;
   logic [ACC_W:0]   sum;

   assign sum  = {1'b0, acc} + {1'b0, INC};
   assign tick = ~clr & sum[ACC_W];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         acc <= '0;
      end else if (clr) begin
         acc <= '0;
      end else begin
         acc <= sum[ACC_W-1:0];
      end
   end

endmodule

// File: rtl/usb_audio_i2s_tx.sv
// I2S serialiser for 16-bit stereo PCM with NCO-derived BCLK/LRCK.
// Optional 256 fs master clock output under `define I2S_TX_MCLK_EN.
module usb_audio_i2s_tx
   import usb_audio_pkg::*;
#(
   parameter int               ACC_W     = 24,
`ifdef I2S_TX_MCLK_EN
   parameter logic [ACC_W-1:0] MCLK_INC  = 24'd6871948,
`endif
   parameter logic [ACC_W-1:0] PHASE_INC = 24'd1717987
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             mute,
   input  logic [PCM_W-1:0] audio_lch,
   input  logic [PCM_W-1:0] audio_rch,
   output logic             i2s_bclk,
   output logic             i2s_lrck,
   output logic             i2s_sdata,
   output logic             frame_start,
`ifdef I2S_TX_MCLK_EN
   output logic             i2s_mclk,
`endif
   output i2s_state_t       state_dbg
);

   localparam int POS_W = $clog2(I2S_FRAME_BITS);

   i2s_state_t                state, state_nxt;
   logic                      tick, fall, wrap, go_idle;
   logic [POS_W-1:0]          pos, pos_nxt;
   logic [I2S_FRAME_BITS-1:0] sr;
   logic [PCM_W-1:0]          l_smp, r_smp;

   usb_audio_nco #(.ACC_W(ACC_W), .INC(PHASE_INC)) u_bclk_nco (
      .clk  (clk),
      .rst  (rst),
      .clr  (state == IDLE),
      .tick (tick)
   );

   assign fall      = tick & i2s_bclk;
   assign wrap      = (pos == POS_W'(I2S_FRAME_BITS - 1));
   assign pos_nxt   = pos + POS_W'(1);
   assign l_smp     = mute ? '0 : audio_lch;
   assign r_smp     = mute ? '0 : audio_rch;
   assign state_dbg = state;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // DRAIN ends on the falling edge that would open a new frame, unless en came back.
   always_comb begin
      state_nxt = state;
      go_idle   = 1'b0;
      case (state)
         IDLE:    if (en) state_nxt = RUN;
         RUN:     if (!en) state_nxt = DRAIN;
         DRAIN: begin
            if (en) begin
               state_nxt = RUN;
            end else if (fall && wrap) begin
               state_nxt = IDLE;
               go_idle   = 1'b1;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         i2s_bclk    <= 1'b0;
         i2s_lrck    <= 1'b1;
         i2s_sdata   <= 1'b0;
         frame_start <= 1'b0;
         pos         <= POS_W'(I2S_FRAME_BITS - 1);
         sr          <= '0;
      end else begin
         frame_start <= 1'b0;
         if (state == IDLE || go_idle) begin
            i2s_bclk  <= 1'b0;
            i2s_lrck  <= 1'b1;
            i2s_sdata <= 1'b0;
            pos       <= POS_W'(I2S_FRAME_BITS - 1);
            sr        <= '0;
         end else if (tick) begin
            if (!i2s_bclk) begin
               i2s_bclk <= 1'b1;
            end else begin
               i2s_bclk <= 1'b0;
               pos      <= pos_nxt;
               if (pos_nxt == '0) begin
                  // Each channel is left-justified in its 32-bit slot, low half zero.
                  i2s_lrck    <= 1'b0;
                  i2s_sdata   <= 1'b0;
                  sr          <= {l_smp, {(I2S_SLOT_BITS-PCM_W){1'b0}},
                                  r_smp, {(I2S_SLOT_BITS-PCM_W){1'b0}}};
                  frame_start <= 1'b1;
               end else begin
                  i2s_sdata <= sr[I2S_FRAME_BITS-1];
                  sr        <= {sr[I2S_FRAME_BITS-2:0], 1'b0};
                  i2s_lrck  <= pos_nxt[POS_W-1];
               end
            end
         end
      end
   end

`ifdef I2S_TX_MCLK_EN
   logic mclk_tick;

   // Free-running in every state so the DAC PLL stays locked while idle.
   usb_audio_nco #(.ACC_W(ACC_W), .INC(MCLK_INC)) u_mclk_nco (
      .clk  (clk),
      .rst  (rst),
      .clr  (1'b0),
      .tick (mclk_tick)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         i2s_mclk <= 1'b0;
      end else if (mclk_tick) begin
         i2s_mclk <= ~i2s_mclk;
      end
   end
`endif

endmodule

// File: tb/tb_usb_audio_i2s_tx.sv
// Directed bench for usb_audio_i2s_tx: frame decode, timing, mute, drain and reset.
module tb_usb_audio_i2s_tx;
   import usb_audio_pkg::*;

   localparam logic [63:0] LRCK_W   = 64'h0000_0000_FFFF_FFFF;
   localparam logic [63:0] F_A5C3   = 64'h52E1_8000_0787_8000;
   localparam logic [63:0] F_1234   = 64'h091A_0000_0787_8000;

   logic        clk = 1'b0;
   logic        rst, en, mute;
   logic [15:0] audio_lch, audio_rch;
   logic        i2s_bclk, i2s_lrck, i2s_sdata, frame_start;
   i2s_state_t  state_dbg;
`ifdef I2S_TX_MCLK_EN
   logic        i2s_mclk;
`endif

   usb_audio_i2s_tx dut (
      .clk         (clk),
      .rst         (rst),
      .en          (en),
      .mute        (mute),
      .audio_lch   (audio_lch),
      .audio_rch   (audio_rch),
      .i2s_bclk    (i2s_bclk),
      .i2s_lrck    (i2s_lrck),
      .i2s_sdata   (i2s_sdata),
      .frame_start (frame_start),
`ifdef I2S_TX_MCLK_EN
      .i2s_mclk    (i2s_mclk),
`endif
      .state_dbg   (state_dbg)
   );

   // clock / cycle counter
   always #5 clk = ~clk;
   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_checks = 0;
   int n_errors = 0;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [63:0] frame_word(input logic [15:0] l, input logic [15:0] r,
                                               input logic m);
      return m ? 64'h0 : {1'b0, l, 16'h0, r, 15'h0};
   endfunction

   // scoreboard / monitor (samples on falling clk edge)
   logic [63:0] exp_q[$];
   logic [63:0] frame_w, lrck_w, last_frame_w, last_lrck_w, exp_w;
   logic        prev_bclk = 1'b0, in_frame = 1'b0, stats_on = 1'b0;
   int bit_cnt = 0, pos_tb = 63, fs_cnt = 0, frames_done = 0;
   int last_fs = 0, last_gap = 0, last_tog = 0, wid = 0, rise_cnt = 0, rise_bad = 0;
   int gap_min, gap_max, wid_min, wid_max;
`ifdef I2S_TX_MCLK_EN
   logic prev_mclk = 1'b0;
   int mclk_cnt = 0, mclk_frame = 0, mclk_fmin, mclk_fmax;
`endif

   task automatic clear_stats();
      gap_min = 1 << 30; gap_max = 0; wid_min = 1 << 30; wid_max = 0; rise_bad = 0;
`ifdef I2S_TX_MCLK_EN
      mclk_fmin = 1 << 30; mclk_fmax = 0;
`endif
   endtask

   always @(negedge clk) begin
      if (rst) begin
         in_frame  = 1'b0;
         bit_cnt   = 0;
         prev_bclk = 1'b0;
`ifdef I2S_TX_MCLK_EN
         prev_mclk = 1'b0;
`endif
      end else begin
`ifdef I2S_TX_MCLK_EN
         if (!prev_mclk && i2s_mclk) begin
            mclk_cnt++;
            mclk_frame++;
         end
         prev_mclk = i2s_mclk;
`endif
         if (i2s_bclk !== prev_bclk) begin
            wid = cyc - last_tog;
            if (stats_on) begin
               if (wid < wid_min) wid_min = wid;
               if (wid > wid_max) wid_max = wid;
            end
            last_tog = cyc;
         end
         if (frame_start) begin
            fs_cnt++;
            last_gap = cyc - last_fs;
            last_fs  = cyc;
            if (stats_on) begin
               if (last_gap < gap_min) gap_min = last_gap;
               if (last_gap > gap_max) gap_max = last_gap;
               if (rise_cnt != 64) rise_bad++;
`ifdef I2S_TX_MCLK_EN
               if (mclk_frame < mclk_fmin) mclk_fmin = mclk_frame;
               if (mclk_frame > mclk_fmax) mclk_fmax = mclk_frame;
`endif
            end
`ifdef I2S_TX_MCLK_EN
            mclk_frame = 0;
`endif
            exp_q.push_back(frame_word(audio_lch, audio_rch, mute));
            rise_cnt = 0;
            pos_tb   = 0;
            in_frame = 1'b1;
            bit_cnt  = 0;
         end else if (prev_bclk && !i2s_bclk) begin
            pos_tb++;
         end
         if (!prev_bclk && i2s_bclk) begin
            rise_cnt++;
            if (in_frame) begin
               frame_w = {frame_w[62:0], i2s_sdata};
               lrck_w  = {lrck_w[62:0], i2s_lrck};
               bit_cnt++;
               if (bit_cnt == 64) begin
                  in_frame     = 1'b0;
                  last_frame_w = frame_w;
                  last_lrck_w  = lrck_w;
                  frames_done++;
                  check("sb_pending", 64'(exp_q.size() > 0), 64'd1);
                  if (exp_q.size() > 0) begin
                     exp_w = exp_q.pop_front();
                     check("sb_sdata", frame_w, exp_w);
                     check("sb_lrck", lrck_w, LRCK_W);
                  end
               end
            end
         end
         prev_bclk = i2s_bclk;
      end
   end

   // driver tasks
   task automatic tick_n(input int n);
      repeat (n) begin
         @(negedge clk);
         #1;
      end
   endtask

   task automatic next_frame();
      int c0 = fs_cnt;
      for (int i = 0; i < 3000; i++) begin
         tick_n(1);
         if (fs_cnt != c0) return;
      end
      check("timeout_frame_start", 64'(fs_cnt), 64'(c0 + 1));
   endtask

   task automatic wait_frames(input int n);
      int target = frames_done + n;
      for (int i = 0; i < 1400 * n + 200; i++) begin
         tick_n(1);
         if (frames_done >= target) return;
      end
      check("timeout_frames", 64'(frames_done), 64'(target));
   endtask

   task automatic wait_pos(input int p);
      for (int i = 0; i < 1400; i++) begin
         tick_n(1);
         if (pos_tb == p) return;
      end
      check("timeout_pos", 64'(pos_tb), 64'(p));
   endtask

   int c0, t0, fc;
`ifdef I2S_TX_MCLK_EN
   int m0;
`endif

   initial begin
      rst = 1'b1; en = 1'b0; mute = 1'b0; audio_lch = '0; audio_rch = '0;
      clear_stats();
      tick_n(3);
      check("rst_bclk", 64'(i2s_bclk), 64'd0);
      check("rst_lrck", 64'(i2s_lrck), 64'd1);
      check("rst_sdata", 64'(i2s_sdata), 64'd0);
      check("rst_fs", 64'(frame_start), 64'd0);
      check("rst_state", 64'(state_dbg), 64'(IDLE));
`ifdef I2S_TX_MCLK_EN
      check("rst_mclk", 64'(i2s_mclk), 64'd0);
`endif
      rst = 1'b0;
      tick_n(5);
      check("idle_lrck", 64'(i2s_lrck), 64'd1);

      // 1: first frame from idle
      audio_lch = 16'hA5C3; audio_rch = 16'h0F0F;
      c0 = cyc;
      en = 1'b1;
      next_frame();
      check("t1_latency", 64'((cyc - c0) >= 19 && (cyc - c0) <= 23), 64'd1);
      wait_frames(1);
      check("t1_frame", last_frame_w, F_A5C3);
      check("t1_lrck", last_lrck_w, LRCK_W);

      // 2: 100 frames of timing
      next_frame();
      t0 = last_fs;
      clear_stats();
`ifdef I2S_TX_MCLK_EN
      m0 = mclk_cnt;
`endif
      stats_on = 1'b1;
      repeat (100) next_frame();
      stats_on = 1'b0;
      check("t2_gap_min", 64'(gap_min >= 1249), 64'd1);
      check("t2_gap_max", 64'(gap_max <= 1251), 64'd1);
      check("t2_total", 64'((last_fs - t0) >= 124999 && (last_fs - t0) <= 125001), 64'd1);
      check("t2_rises_per_frame", 64'(rise_bad), 64'd0);
      check("t2_bclk_wid_min", 64'(wid_min >= 9), 64'd1);
      check("t2_bclk_wid_max", 64'(wid_max <= 10), 64'd1);
`ifdef I2S_TX_MCLK_EN
      check("t2_mclk_total", 64'((mclk_cnt - m0) >= 25599 && (mclk_cnt - m0) <= 25601), 64'd1);
      check("t2_mclk_fmin", 64'(mclk_fmin >= 255), 64'd1);
      check("t2_mclk_fmax", 64'(mclk_fmax <= 257), 64'd1);
`endif

      // 3: mid-frame input change
      wait_pos(10);
      audio_lch = 16'h1234;
      wait_frames(1);
      check("t3_cur_frame", last_frame_w, F_A5C3);
      wait_frames(1);
      check("t3_next_frame", last_frame_w, F_1234);

      // 4: mute
      wait_pos(10);
      mute = 1'b1; audio_lch = 16'h7FFF; audio_rch = 16'h7FFF;
      wait_frames(1);
      check("t4_pre_mute", last_frame_w, F_1234);
      wait_frames(1);
      check("t4_muted", last_frame_w, 64'h0);
      check("t4_lrck", last_lrck_w, LRCK_W);
      mute = 1'b0; audio_lch = 16'hA5C3; audio_rch = 16'h0F0F;

      // 5: drain to idle, then re-raise en during drain
      wait_pos(20);
      fc = fs_cnt;
      en = 1'b0;
      wait_frames(1);
      check("t5_drain_frame", last_frame_w, F_A5C3);
      tick_n(40);
      check("t5_idle_bclk", 64'(i2s_bclk), 64'd0);
      check("t5_idle_lrck", 64'(i2s_lrck), 64'd1);
      check("t5_idle_sdata", 64'(i2s_sdata), 64'd0);
      check("t5_idle_state", 64'(state_dbg), 64'(IDLE));
      tick_n(1500);
      check("t5_no_frame_start", 64'(fs_cnt - fc), 64'd0);
      check("t5_still_idle_bclk", 64'(i2s_bclk), 64'd0);
      en = 1'b1;
      next_frame();
      wait_pos(20);
      en = 1'b0;
      wait_pos(40);
      check("t5_in_drain", 64'(state_dbg), 64'(DRAIN));
      en = 1'b1;
      next_frame();
      check("t5_no_gap", 64'(last_gap >= 1249 && last_gap <= 1251), 64'd1);
      check("t5_back_run", 64'(state_dbg), 64'(RUN));

      // 6: reset mid-frame
      wait_pos(40);
      rst = 1'b1;
      #1;
      check("t6_rst_bclk", 64'(i2s_bclk), 64'd0);
      check("t6_rst_lrck", 64'(i2s_lrck), 64'd1);
      check("t6_rst_sdata", 64'(i2s_sdata), 64'd0);
      check("t6_rst_fs", 64'(frame_start), 64'd0);
`ifdef I2S_TX_MCLK_EN
      check("t6_rst_mclk", 64'(i2s_mclk), 64'd0);
`endif
      if (exp_q.size() > 0) void'(exp_q.pop_back());
      tick_n(3);
      rst = 1'b0;
      next_frame();
      wait_frames(1);
      check("t6_first_frame", last_frame_w, F_A5C3);
      check("t6_first_lrck", last_lrck_w, LRCK_W);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
